// File: rtl/bell_pkg.sv
// Purpose : shared types and helpers for the bell melody sequencer.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: NOTES_MAX, REST_CODE, note_t, seq_entry_t, seq_state_t, note2onehot().
package bell_pkg;

  localparam int         NOTES_MAX = 20;
  localparam int         SEQ_DUR_W = 8;
  localparam logic [4:0] REST_CODE = 5'd31;

  typedef logic [4:0] note_t;

  typedef struct packed {
    note_t                note;
    logic [SEQ_DUR_W-1:0] dur;
  } seq_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  // Note n lights bit NOTES_MAX-1-n, so note 0 is the MSB. Any code at or
  // above NOTES_MAX (including REST_CODE) matches no bit and yields zero.
  function automatic logic [NOTES_MAX-1:0] note2onehot(input note_t n);
    logic [NOTES_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < NOTES_MAX; i++) begin
      if (int'(n) == NOTES_MAX - 1 - i) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bell_seq_table.sv
// Purpose : DEPTH-entry note table, one write port, one registered read port.
// Latency : read data valid the cycle after rd_en; writes visible the cycle after wr_en.
// Backpres: none; both ports accept every cycle.
// Ports   : clk, _rst (async active-low), wr_en/wr_addr/wr_dat, rd_en/rd_addr -> rd_dat.
module bell_seq_table
  import bell_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  seq_entry_t      wr_dat,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output seq_entry_t      rd_dat
);

  localparam seq_entry_t RST_ENTRY = '{note: REST_CODE, dur: '0};

  seq_entry_t mem_q [DEPTH];
  seq_entry_t mem_d [DEPTH];
  seq_entry_t rd_q;
  seq_entry_t rd_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    if (wr_en) mem_d[wr_addr] = wr_dat;
    // Read from mem_q, not mem_d: a write landing on the same edge as the
    // read is not forwarded, so the reader sees the pre-write entry.
    if (rd_en) rd_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
      rd_q <= RST_ENTRY;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_dat = rd_q;

endmodule

// File: rtl/bell_seq_ctrl.sv
// Purpose : melody sequencer; steps through the note table, drives one-hot divider enables.
// Latency : start -> first sel bit 2 cycles; note held dur ticks, then GAP_MS silent ticks.
// Backpres: none; start ignored while busy, stop aborts from any active state.
// Ports   : clk, _rst, tick, start, stop, [loop], wr_en/wr_addr/wr_note/wr_dur -> sel, busy, done, step.
// Option  : BELL_SEQ_LOOP_EN adds input 'loop' to restart at entry 0 instead of finishing.
module bell_seq_ctrl
  import bell_pkg::*;
#(
  parameter  int NOTES  = NOTES_MAX,
  parameter  int DEPTH  = 16,
  parameter  int DUR_W  = SEQ_DUR_W,
  parameter  int GAP_MS = 10,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
`ifdef BELL_SEQ_LOOP_EN
  input  logic             loop,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [4:0]       wr_note,
  input  logic [DUR_W-1:0] wr_dur,
  output logic [NOTES-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step
);

  localparam int            GW       = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_MS);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    step_q, step_d;
  note_t            note_q, note_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NOTES-1:0] sel_q, sel_d;

  logic       loop_on;
  logic       rd_en;
  seq_entry_t wr_dat;
  seq_entry_t rd_dat;

`ifdef BELL_SEQ_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign wr_dat = '{note: wr_note, dur: SEQ_DUR_W'(wr_dur)};

  bell_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    ._rst    (_rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_en   (rd_en),
    .rd_addr (addr_d),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    step_d    = step_q;
    note_d    = note_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;

    if (stop && (state_q != IDLE)) begin
      // Abort beats every other transition; counters simply go stale.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
        FETCH: begin
          if (rd_dat.dur == '0) begin
            // Looping only rewinds if entry 0 was not itself the end marker,
            // otherwise an empty table would spin forever.
            if (loop_on && (addr_q != '0)) begin
              state_d = FETCH;
              addr_d  = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d   = PLAY;
            dur_cnt_d = DUR_W'(rd_dat.dur);
            note_d    = rd_dat.note;
            step_d    = addr_q;
          end
        end
        PLAY: begin
          if (tick) begin
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
            if (dur_cnt_q == DUR_W'(1)) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end
          end
        end
        GAP: begin
          // Zero-length gap exits on the first GAP cycle.
          if ((gap_cnt_q == '0) || (tick && (gap_cnt_q == GW'(1)))) begin
            gap_cnt_d = '0;
            if (addr_q == LAST) begin
              if (loop_on) begin
                state_d = FETCH;
                addr_d  = '0;
              end else begin
                state_d = DONE;
              end
            end else begin
              state_d = FETCH;
              addr_d  = addr_q + AW'(1);
            end
          end else if (tick) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Table read is issued on the edge entering FETCH so the entry is
    // available for the FETCH decision itself.
    rd_en = (state_d == FETCH);
    // sel tracks the next state so it rises and falls with PLAY exactly.
    sel_d = (state_d == PLAY) ? NOTES'(note2onehot(note_d)) : '0;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      step_q    <= '0;
      note_q    <= REST_CODE;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      step_q    <= step_d;
      note_q    <= note_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sel_q     <= sel_d;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign step = step_q;

endmodule

// File: doc/bell_seq_ctrl.md
Name: bell_seq_ctrl

Overview:
- Melody sequencer for the bell tone datapath: stores a short programmable note table and steps through it on a start request.
- Drives the one-hot enable vector of the 20-entry tone-divider bank. Each entry's tone is held for a programmed number of 1 kHz ticks, followed by a fixed silent gap.
- Sits between the button detectors / 1 kHz prescaler and the divider bank. It replaces the manual button-shifted one-hot register when automatic playback is selected.

Parameters:
- NOTES, 20, number of tone dividers; width of sel.
- DEPTH, 16, note-table entries; address width is clog2(DEPTH).
- DUR_W, 8, duration field width, in 1 kHz ticks.
- GAP_MS, 10, silent ticks inserted after every note; 0 means no gap.

Ports:
- clk  in  1  system clock.
- _rst  in  1  asynchronous active-low reset.
- tick  in  1  1 kHz strobe, one clk cycle wide.
- start  in  1  single-cycle play request, from the edge detector.
- stop  in  1  single-cycle abort request.
- wr_en  in  1  table write strobe.
- wr_addr  in  clog2(DEPTH)  table write address.
- wr_note  in  5  note index: 0..NOTES-1 is a tone; any value >= NOTES is a rest.
- wr_dur  in  DUR_W  duration in ticks; 0 marks end-of-sequence.
- sel  out  NOTES  one-hot divider enable; note n drives sel[NOTES-1-n].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal sequence completion.
- step  out  clog2(DEPTH)  address of the entry currently playing.

Behaviour:
- Reset: state=IDLE, sel=0, busy=0, done=0, step=0, counters=0. All table entries reset to {note=31, dur=0}.
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0 -> FETCH with addr=0.
  - start ignored in every other state.
- FETCH (1 cycle):
  - Registered read of table[addr].
  - dur==0 -> DONE.
  - Otherwise load dur_cnt=dur, step=addr -> PLAY.
- PLAY:
  - sel = one-hot of note, or all-zero for a rest.
  - Each tick decrements dur_cnt. The tick that takes dur_cnt from 1 to 0 moves to GAP on the next cycle, so a note lasts exactly dur ticks after PLAY entry.
  - sel returns to 0 in the same cycle the state leaves PLAY.
- GAP:
  - sel=0. gap_cnt loaded with GAP_MS and decremented on tick.
  - At 0: addr==DEPTH-1 -> DONE; otherwise addr+1 -> FETCH.
  - GAP_MS=0: PLAY goes directly to the GAP exit decision in one cycle.
- DONE (1 cycle): done=1, busy=1 -> IDLE. step holds its last value.
- stop:
  - In any non-IDLE state, forces IDLE on the next edge with sel=0. No done pulse.
  - stop wins over a simultaneous start, and over any same-cycle state transition.
- Table writes:
  - Accepted in every state; take effect at the next fetch of that address.
  - Write and FETCH on the same address in the same cycle: FETCH returns the old value.
- Asynchronous reset mid-playback: sel is cleared immediately (combinational path from _rst is not required; sel is a register with async clear).
- sel is never more than one-hot. Note values >= NOTES never set any bit.

Optional Feature:
- Macro: BELL_SEQ_LOOP_EN.
- Defined:
  - Adds input loop (1 bit).
  - When loop=1 at the DONE decision, the state goes to FETCH with addr=0 instead of IDLE, and no done pulse is produced.
  - stop is the only exit from a looping sequence.
  - An all-empty table (entry 0 dur==0) still terminates normally, with a done pulse, to avoid a zero-length spin.
- Not defined: no loop port; behaviour exactly as above.

Decomposition:
- Package bell_pkg:
  - NOTES_MAX=20 and REST_CODE=5'd31.
  - typedef note_t (logic [4:0]).
  - typedef seq_entry_t struct {note_t note; logic [DUR_W-1:0] dur}.
  - enum seq_state_t {IDLE, FETCH, PLAY, GAP, DONE}.
  - function note2onehot(note_t) returning the NOTES-bit vector with the reversed bit order.
- Sub-module bell_seq_table:
  - DEPTH x seq_entry_t register file.
  - Async-clear, one write port, one registered read port.
  - Old-data-on-collision rule lives here.
- Sequencer FSM and counters stay in bell_seq_ctrl.

Test Plan:
- Program entries {note 0, dur 3}, {note 19, dur 2}, {dur 0}; GAP_MS=2; pulse start -> sel=20'h80000 for exactly 3 ticks, 0 for 2 ticks, then 20'h00001 for 2 ticks, 0 for 2 ticks, then done pulse one cycle after the end-of-sequence FETCH; busy falls with it.
- Entry 0 = {note 25, dur 4} -> sel stays 0 for 4 ticks (rest); busy=1 throughout; step=0.
- Pulse stop during the second tick of a dur=5 note -> next cycle state=IDLE, sel=0, busy=0, no done pulse. Then start restarts from addr 0.
- Fill all 16 entries with dur=1 (no end marker) -> playback visits step 0..15, and done fires after the gap of entry 15.
- Same-cycle write {note 7, dur 9} to addr 1 while FETCH reads addr 1 -> old entry plays. The next run plays note 7 (sel=20'h01000) for 9 ticks.
- With BELL_SEQ_LOOP_EN and loop=1, two-entry table -> step sequence 0,1,0,1,... with no done pulse. Pulse stop -> IDLE within one cycle.
